// File: rtl/rvfi_pkg.sv
// rtl/rvfi_pkg.sv - RVFI commit record as presented by the core on each commit port
package rvfi_pkg;

   typedef struct packed {
      logic        valid;
      logic [63:0] order;
      logic [31:0] insn;
      logic        trap;
      logic [31:0] pc_rdata;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
   } rvfi_instr_t;

endpackage

// File: rtl/rvfi_trace_pkg.sv
// rtl/rvfi_trace_pkg.sv - trace entry type, serializer FSM states and end-of-test constant
package rvfi_trace_pkg;
   import rvfi_pkg::*;

   // Wide enough for up to 16 commit ports; the top slices it to its own port width.
   localparam int unsigned TRACE_PORT_W = 4;
   localparam logic [31:0] ECALL_INSN   = 32'h00000073;

   typedef struct packed {
      rvfi_instr_t              rvfi;
      logic [TRACE_PORT_W-1:0]  port;
      logic [63:0]              seq;
   } trace_entry_t;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_DONE,
      ST_TIMEOUT
   } ser_state_e;

   function automatic logic is_end_of_test(input rvfi_instr_t r);
      return r.valid && (r.insn == ECALL_INSN);
   endfunction

endpackage

// File: rtl/rvfi_mw_fifo.sv
// rtl/rvfi_mw_fifo.sv - multi-write, single-read FIFO of trace entries
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_wr_cnt       number of entries to push this cycle (taken from i_wr_data[0..cnt-1])
//   i_wr_data      compacted push entries, slot 0 is written first
//   i_rd_en        pop head (ignored when empty)
//   o_rd_data      head entry (contents undefined when empty)
//   o_empty        FIFO holds no entries
//   o_count        occupancy
// The caller guarantees i_wr_cnt never exceeds the free space at cycle start.
module rvfi_mw_fifo
   import rvfi_trace_pkg::*;
#(
   parameter int unsigned NR_WR = 2,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(NR_WR + 1)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [CW-1:0]            i_wr_cnt,
   input  trace_entry_t [NR_WR-1:0] i_wr_data,
   input  logic                     i_rd_en,
   output trace_entry_t             o_rd_data,
   output logic                     o_empty,
   output logic [AW:0]              o_count
);

   trace_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_rd;

   assign w_rd = i_rd_en && (r_count != '0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(i_wr_cnt);
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + (AW+1)'(i_wr_cnt) - (AW+1)'(w_rd);
      end
   end

   // Storage needs no reset: nothing is visible until it has been written.
   always_ff @(posedge i_clk) begin
      for (int k = 0; k < NR_WR; k++) begin
         if (CW'(k) < i_wr_cnt) begin
            r_mem[r_wr_ptr + AW'(k)] <= i_wr_data[k];
         end
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;

endmodule

// File: rtl/rvfi_commit_serializer.sv
// rtl/rvfi_commit_serializer.sv - serializes multi-port RVFI commits into one ordered trace stream
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   rvfi_i           commit ports sampled every cycle
//   trace_valid_o    head entry available; trace_ready_i pops it
//   trace_o          head payload, trace_port_o its source port, trace_seq_o its sequence number
//   stall_o          fewer than NR_COMMIT_PORTS free entries at cycle start
//   overflow_o       sticky, an entry was dropped for lack of space
//   done_o           sticky, end-of-test ecall enqueued and drained
//   timeout_o        sticky, watchdog expired
module rvfi_commit_serializer
   import rvfi_pkg::*;
   import rvfi_trace_pkg::*;
#(
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned FIFO_DEPTH      = 8,
   parameter int unsigned TIMEOUT_CYCLES  = 2000000,
   localparam int unsigned PW = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
   output logic                              trace_valid_o,
   input  logic                              trace_ready_i,
   output rvfi_instr_t                       trace_o,
   output logic [PW-1:0]                     trace_port_o,
   output logic [63:0]                       trace_seq_o,
   output logic                              stall_o,
   output logic                              overflow_o,
   output logic                              done_o,
   output logic                              timeout_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(NR_COMMIT_PORTS + 1);

   ser_state_e   r_state;
   logic         r_done;
   logic         r_timeout;
   logic         r_overflow;
   logic [63:0]  r_seq;
   logic [31:0]  r_cycles;

   trace_entry_t [NR_COMMIT_PORTS-1:0] w_wr_data;
   logic [CW-1:0] w_wr_cnt;
   logic          w_drop;
   logic          w_ecall;
   logic          w_timeout;
   logic          w_empty;
   logic          w_pop;
   logic [AW:0]   w_count;
   logic [AW:0]   w_free;
   trace_entry_t  w_head;
   trace_entry_t  w_head_m;
   logic [TRACE_PORT_W-1:0] w_unused_port_bits;

   // Free space is judged on cycle-start occupancy only, so a pop in the
   // same cycle never makes room for pushes.
   assign w_free    = (AW+1)'(FIFO_DEPTH) - w_count;
   assign w_pop     = !w_empty && trace_ready_i;
   assign w_timeout = (r_cycles > TIMEOUT_CYCLES);

   // Compact qualifying ports into FIFO slots in ascending port order. An
   // enqueued ecall stops the scan: later ports are discarded silently, not
   // counted as overflow.
   always_comb begin
      int   n;
      logic stop;
      n       = 0;
      stop    = 1'b0;
      w_drop  = 1'b0;
      w_ecall = 1'b0;
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         w_wr_data[k] = '0;
      end
      if (r_state == ST_RUN) begin
         for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (!stop && (rvfi_i[i].valid || rvfi_i[i].trap)) begin
               if (n < int'(w_free)) begin
                  for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
                     if (k == n) begin
                        w_wr_data[k].rvfi = rvfi_i[i];
                        w_wr_data[k].port = TRACE_PORT_W'(i);
                        w_wr_data[k].seq  = r_seq + 64'(k);
                     end
                  end
                  if (is_end_of_test(rvfi_i[i])) begin
                     w_ecall = 1'b1;
                     stop    = 1'b1;
                  end
                  n = n + 1;
               end else begin
                  w_drop = 1'b1;
               end
            end
         end
      end
      w_wr_cnt = CW'(n);
   end

   rvfi_mw_fifo #(
      .NR_WR (NR_COMMIT_PORTS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk     (clk_i),
      .i_rst     (rst_i),
      .i_wr_cnt  (w_wr_cnt),
      .i_wr_data (w_wr_data),
      .i_rd_en   (w_pop),
      .o_rd_data (w_head),
      .o_empty   (w_empty),
      .o_count   (w_count)
   );

   // Timeout takes priority over both the ecall transition and drain completion.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= ST_RUN;
         r_done     <= 1'b0;
         r_timeout  <= 1'b0;
         r_overflow <= 1'b0;
         r_seq      <= '0;
         r_cycles   <= '0;
      end else begin
         if (r_cycles != '1) begin
            r_cycles <= r_cycles + 32'd1;
         end
         r_seq <= r_seq + 64'(w_wr_cnt);
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         case (r_state)
            ST_RUN: begin
               if (w_timeout) begin
                  r_state   <= ST_TIMEOUT;
                  r_timeout <= 1'b1;
               end else if (w_ecall) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_timeout) begin
                  r_state   <= ST_TIMEOUT;
                  r_timeout <= 1'b1;
               end else if (w_empty) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Head is forced to zero when empty so stale storage never leaks out.
   assign w_head_m           = w_empty ? '0 : w_head;
   assign w_unused_port_bits = w_head_m.port;

   assign trace_valid_o = !w_empty;
   assign trace_o       = w_head_m.rvfi;
   assign trace_port_o  = w_head_m.port[PW-1:0];
   assign trace_seq_o   = w_head_m.seq;
   assign stall_o       = (w_free < (AW+1)'(NR_COMMIT_PORTS));
   assign overflow_o    = r_overflow;
   assign done_o        = r_done;
   assign timeout_o     = r_timeout;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// tb/tb_rvfi_commit_serializer.sv - randomized and directed bench with a queue-based reference model
module tb_rvfi_commit_serializer;
   import rvfi_pkg::*;

   localparam int NR    = 2;
   localparam int DEPTH = 8;
   localparam int TMO   = 20;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   rvfi_instr_t [NR-1:0] rvfi = '0;
   logic                 trace_ready = 1'b0;
   logic                 trace_valid;
   rvfi_instr_t          trace;
   logic [0:0]           trace_port;
   logic [63:0]          trace_seq;
   logic                 stall, overflow, done, timeout;

   rvfi_commit_serializer #(
      .NR_COMMIT_PORTS (NR),
      .FIFO_DEPTH      (DEPTH),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .rvfi_i        (rvfi),
      .trace_valid_o (trace_valid),
      .trace_ready_i (trace_ready),
      .trace_o       (trace),
      .trace_port_o  (trace_port),
      .trace_seq_o   (trace_seq),
      .stall_o       (stall),
      .overflow_o    (overflow),
      .done_o        (done),
      .timeout_o     (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      rvfi_instr_t     ins;
      int              port;
      longint unsigned seq;
   } m_entry_t;

   m_entry_t        mq[$];
   longint unsigned m_seq;
   int unsigned     m_cycles;
   bit              m_ovf, m_drain, m_done, m_to;
   int              n_checks = 0;
   int              n_errors = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_seq    = 0;
      m_cycles = 0;
      m_ovf    = 0;
      m_drain  = 0;
      m_done   = 0;
      m_to     = 0;
   endtask

   task automatic check_outputs();
      check("valid", trace_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         check("trace", trace, mq[0].ins);
         check("port", trace_port, mq[0].port);
         check("seq", trace_seq, mq[0].seq);
      end else begin
         check("trace_idle", trace, 0);
         check("seq_idle", trace_seq, 0);
      end
      check("stall", stall, (DEPTH - mq.size()) < NR);
      check("overflow", overflow, m_ovf);
      check("done", done, m_done);
      check("timeout", timeout, m_to);
   endtask

   // One clock: check current outputs, drive inputs, advance the model, then
   // return at the next falling edge.
   task automatic step(input rvfi_instr_t [NR-1:0] ins, input bit rdy);
      int       n, free;
      bit       stop, pop, ecall, tnow, was_empty, running;
      m_entry_t nq[$];
      check_outputs();
      rvfi        = ins;
      trace_ready = rdy;
      was_empty = (mq.size() == 0);
      free      = DEPTH - mq.size();
      pop       = !was_empty && rdy;
      running   = !m_drain && !m_done && !m_to;
      n = 0; stop = 0; ecall = 0;
      if (running) begin
         for (int i = 0; i < NR; i++) begin
            if (!stop && (ins[i].valid || ins[i].trap)) begin
               if (n < free) begin
                  nq.push_back('{ins[i], i, m_seq + longint'(n)});
                  n++;
                  if (ins[i].valid && ins[i].insn == 32'h00000073) begin
                     ecall = 1;
                     stop  = 1;
                  end
               end else begin
                  m_ovf = 1;
               end
            end
         end
      end
      tnow = (running || m_drain) && (m_cycles > TMO);
      if (running) begin
         if (tnow) m_to = 1;
         else if (ecall) m_drain = 1;
      end else if (m_drain) begin
         if (tnow) begin m_to = 1; m_drain = 0; end
         else if (was_empty) begin m_done = 1; m_drain = 0; end
      end
      if (pop) void'(mq.pop_front());
      foreach (nq[j]) mq.push_back(nq[j]);
      m_seq += longint'(n);
      if (m_cycles != 32'hFFFF_FFFF) m_cycles++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_valid", trace_valid, 0);
      check("rst_trace", trace, 0);
      check("rst_port", trace_port, 0);
      check("rst_seq", trace_seq, 0);
      check("rst_ovf", overflow, 0);
      check("rst_done", done, 0);
      check("rst_to", timeout, 0);
      check("rst_stall", stall, 0);
      rvfi        = '0;
      trace_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   function automatic rvfi_instr_t rand_ins(input int pv, input int pt, input int pe);
      rvfi_instr_t r;
      r.valid    = $urandom_range(99) < pv;
      r.trap     = $urandom_range(99) < pt;
      r.order    = {$urandom, $urandom};
      r.insn     = ($urandom_range(99) < pe) ? 32'h00000073 : ($urandom | 32'h1);
      r.pc_rdata = $urandom;
      r.rd_addr  = 5'($urandom);
      r.rd_wdata = $urandom;
      return r;
   endfunction

   function automatic rvfi_instr_t plain(input logic v, input logic t);
      rvfi_instr_t r;
      r = rand_ins(0, 0, 0);
      r.valid = v;
      r.trap  = t;
      return r;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rvfi_instr_t [NR-1:0] ins;
      @(negedge clk);

      // Both ports valid, ready high: alternating ports, contiguous seq
      do_reset();
      for (int c = 0; c < 5; c++) begin
         ins[0] = plain(1, 0); ins[1] = plain(1, 0);
         step(ins, 1);
      end
      for (int c = 0; c < 10; c++) step('0, 1);
      check("r035_ovf", overflow, 1'b0);

      // Sink blocked for 10 cycles: fill, stall, overflow, then drain 0..7
      do_reset();
      for (int c = 0; c < 10; c++) begin
         ins[0] = plain(1, 0); ins[1] = plain(1, 0);
         step(ins, 0);
      end
      check("r036_ovf", overflow, 1'b1);
      check("r036_stall", stall, 1'b1);
      check("r036_seq0", trace_seq, 64'd0);
      for (int c = 0; c < 10; c++) step('0, 1);

      // Ecall on port 0 with port 1 valid: port 1 discarded, done afterwards
      do_reset();
      ins[0] = plain(1, 0); ins[0].insn = 32'h00000073; ins[1] = plain(1, 0);
      step(ins, 1);
      for (int c = 0; c < 4; c++) step('0, 1);
      check("r037_done", done, 1'b1);
      check("r037_ovf", overflow, 1'b0);

      // Watchdog: timeout visible from cycle TMO+2, buffered entries drain
      do_reset();
      for (int c = 0; c < 26; c++) begin
         if (c == TMO + 1) check("r038_before", timeout, 1'b0);
         if (c == TMO + 2) check("r038_at", timeout, 1'b1);
         ins[0] = plain(1, 0); ins[1] = plain(1, 0);
         step(ins, 0);
      end
      for (int c = 0; c < 12; c++) begin
         ins[0] = plain(1, 0); ins[1] = plain(1, 0);
         step(ins, 1);
      end
      check("r038_empty", trace_valid, 1'b0);

      // Trap-only entry on port 0
      do_reset();
      ins[0] = plain(0, 1); ins[1] = plain(0, 0);
      step(ins, 0);
      check("r039_valid", trace_valid, 1'b1);
      check("r039_port", trace_port, 1'b0);
      check("r039_trap", trace.trap, 1'b1);
      step('0, 1);

      // Reset with 5 buffered entries and overflow set
      do_reset();
      for (int c = 0; c < 5; c++) begin
         ins[0] = plain(1, 0); ins[1] = plain(1, 0);
         step(ins, 0);
      end
      for (int c = 0; c < 3; c++) step('0, 1);
      check("r040_ovf_pre", overflow, 1'b1);
      do_reset();
      ins[0] = plain(1, 0); ins[1] = plain(0, 0);
      step(ins, 0);
      check("r040_seq", trace_seq, 64'd0);
      step('0, 1);

      // Randomized segments with varying sink pressure and ecall density
      for (int s = 0; s < 30; s++) begin
         int len, prdy, pe;
         do_reset();
         len  = $urandom_range(10, 40);
         prdy = $urandom_range(0, 100);
         pe   = $urandom_range(0, 8);
         for (int c = 0; c < len; c++) begin
            for (int i = 0; i < NR; i++) ins[i] = rand_ins(70, 10, pe);
            step(ins, $urandom_range(99) < prdy);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
